disbus_master: RTL and testbench
================================

Name: disbus_master

Overview:
- Hardware initiator for the two-wire DISCLK/DISDAT display-driver bus, i.e. the I2C-like bus the u3090mg responder sits on. Today the slave micro bit-bangs this bus.
- Lets HLE logic or a test harness issue byte-level bus commands (START, WRITE, READ, STOP) and receive ack/data responses.
- Drives SCL and an open-drain SDA; the wired-AND SDA level is fed back in.

Parameters:
- HALF, 8, clk cycles per bus phase (one half SCL period); minimum 2.

Ports:
- clk  in  1  system clock (clk30 domain)
- reset  in  1  asynchronous, active-low (0 = reset); one clock; reset is asynchronous and active-low
- cmd_valid  in  1  command offered
- cmd_ready  out  1  block can accept a command
- cmd_op  in  2  disbus_pkg::op_t: START=0, WRITE=1, READ=2, STOP=3
- cmd_data  in  8  byte for WRITE
- cmd_nack  in  1  READ only: 1 = send NACK after the byte (last read)
- rsp_valid  out  1  one-cycle pulse on WRITE/READ completion
- rsp_data  out  8  byte received by READ; 0 for WRITE
- rsp_ack  out  1  WRITE: responder pulled SDA low in the ack slot
- rsp_err  out  1  WRITE/READ issued while no transaction is open
- bus_active  out  1  set after START completes, cleared after STOP completes
- scl  out  1  bus clock
- sda_out  out  1  0 = pull SDA low, 1 = release
- sda_in  in  1  wired-AND SDA line level

Behaviour:
- Reset (async, reset=0):
  - scl=1, sda_out=1, cmd_ready=1, rsp_valid=0, rsp_data=0, rsp_ack=0, rsp_err=0, bus_active=0.
  - State returns to IDLE immediately, including mid-byte.
- Phase timer:
  - Counts HALF cycles per phase; a phase ends when the counter reaches HALF-1.
  - Line changes take effect on the first cycle of a phase.
- Handshake:
  - A command is accepted when cmd_valid && cmd_ready. cmd_ready drops the next cycle.
  - cmd_ready re-asserts in the cycle the command finishes. For WRITE/READ that is the same cycle as rsp_valid.
  - cmd_data and cmd_nack are latched at accept.
- START (4 phases, also used as repeated start):
  - S0: sda_out=1, scl unchanged.
  - S1: scl=1.
  - S2: sda_out=0.
  - S3: scl=0.
  - On S3 end, bus_active=1 and the command is done.
- WRITE, when bus_active=1: 9 bits, each a LOW phase then a HIGH phase.
  - Bits 7..0: LOW sets sda_out=cmd_data[bit], MSB first; HIGH sets scl=1; scl returns to 0 at the next LOW.
  - Ack bit: sda_out=1; sample sda_in on the last cycle of HIGH; rsp_ack = !sda_in.
  - After the ack HIGH, one trailing phase drives scl=0 (sda_out stays 1), then rsp_valid.
  - Total: 19*HALF cycles from accept to rsp_valid.
- READ, when bus_active=1:
  - Bits 7..0: sda_out=1; sample sda_in into rsp_data[bit] on the last HIGH cycle.
  - Ack bit: sda_out = cmd_nack ? 1 : 0.
  - Same trailing phase and timing as WRITE. rsp_ack=0.
- STOP, when bus_active=1 (3 phases):
  - P0: sda_out=0, scl=0.
  - P1: scl=1.
  - P2: sda_out=1.
  - Then bus_active=0 and idle with scl=1.
- STOP when bus_active=0: no bus activity; completes in 1 cycle.
- WRITE/READ when bus_active=0: no bus activity; rsp_valid with rsp_err=1, rsp_ack=0, rsp_data=0, 1 cycle after accept.
- rsp_* hold their values until the next rsp_valid. rsp_err is cleared on the next valid response.
- scl only changes at phase boundaries. sda_out never changes while scl=1, except the S2 and P2 edges (START/STOP conditions).
- No clock stretching and no arbitration. sda_in mismatch during a WRITE bit is ignored.

Decomposition:
- disbus_pkg: op_t enum; state enum (IDLE, START, BIT_LO, BIT_HI, TRAIL, STOP, RESP); bit counter width (4 bits, 0..8).
- One sub-module, disbus_phase_timer: parameter HALF; ports start, tick_end. Used for all phase timing.
- Main FSM, shift register and response logic live in disbus_master.

Test Plan:
- HALF=4, START from idle -> sda falls at cycle 8 after accept with scl=1; scl falls at 12; cmd_ready=1 at 16; bus_active=1.
- START, WRITE 0xA5, responder pulls SDA low in the ack slot -> SDA on scl rising edges is 1,0,1,0,0,1,0,1; rsp_valid exactly 76 cycles after accept; rsp_ack=1, rsp_err=0.
- WRITE 0x74 with sda_in held 1 -> rsp_ack=0, rsp_data=0.
- READ, cmd_nack=1, model drives 0x3C -> rsp_data=0x3C; sda_out=1 through the ack bit. Repeat with cmd_nack=0 -> sda_out=0 during the ack HIGH phase.
- WRITE without START -> rsp_valid with rsp_err=1 one cycle after accept, scl constant 1. STOP with bus_active=0 -> cmd_ready back after 1 cycle.
- reset=0 asserted during bit 3 of a WRITE -> same cycle scl=1, sda_out=1, cmd_ready=1, bus_active=0, no rsp_valid. After release, a fresh START sequence is correct.

Source files
------------

// File: rtl/disbus_pkg.sv
// rtl/disbus_pkg.sv - shared types and constants for the DISCLK/DISDAT bus initiator
package disbus_pkg;

    typedef enum logic [1:0] {
        OP_START = 2'd0,
        OP_WRITE = 2'd1,
        OP_READ  = 2'd2,
        OP_STOP  = 2'd3
    } op_t;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_BIT_LO,
        ST_BIT_HI,
        ST_TRAIL,
        ST_STOP,
        ST_RESP
    } state_t;

    localparam int BIT_CNT_W = 4;
    typedef logic [BIT_CNT_W-1:0] bit_cnt_t;

    localparam bit_cnt_t LAST_DATA_BIT = bit_cnt_t'(7);
    localparam bit_cnt_t ACK_BIT       = bit_cnt_t'(8);

endpackage

// File: rtl/disbus_phase_timer.sv
// rtl/disbus_phase_timer.sv - HALF-cycle phase counter; restarts on start, flags the last cycle of each phase
module disbus_phase_timer #(
    parameter int HALF = 8
) (
    input  logic clk,
    input  logic reset,
    input  logic start,
    output logic tick_end
);

    localparam int CW = $clog2(HALF);
    localparam logic [CW-1:0] LAST = CW'(HALF - 1);

    logic [CW-1:0] cnt;

    // Free-running between commands; phases are back to back so wrapping is the phase boundary.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt <= '0;
        end else if (start || cnt == LAST) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

    assign tick_end = (cnt == LAST);

endmodule

// File: rtl/disbus_master.sv
// rtl/disbus_master.sv - byte-level START/WRITE/READ/STOP initiator driving SCL and open-drain SDA
module disbus_master
    import disbus_pkg::*;
#(
    parameter int HALF = 8
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic [1:0] cmd_op,
    input  logic [7:0] cmd_data,
    input  logic       cmd_nack,
    output logic       rsp_valid,
    output logic [7:0] rsp_data,
    output logic       rsp_ack,
    output logic       rsp_err,
    output logic       bus_active,
    output logic       scl,
    output logic       sda_out,
    input  logic       sda_in
);

    state_t     state_q, state_n;
    logic [1:0] ph_q, ph_n;
    bit_cnt_t   bit_q, bit_n;
    logic [7:0] sh_q, sh_n;
    op_t        op_q, op_n;
    logic       nack_q, nack_n, ack_q, ack_n;
    logic       scl_n, sda_n, ready_n, active_n;
    logic       rv_n, ra_n, re_n;
    logic [7:0] rd_n;
    logic       accept, tick_end;
    op_t        cmd_op_e;

    assign cmd_op_e = op_t'(cmd_op);
    assign accept   = cmd_valid && cmd_ready;

    disbus_phase_timer #(.HALF(HALF)) u_timer (
        .clk      (clk),
        .reset    (reset),
        .start    (accept),
        .tick_end (tick_end)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= ST_IDLE;
            ph_q       <= '0;
            bit_q      <= '0;
            sh_q       <= '0;
            op_q       <= OP_START;
            nack_q     <= 1'b0;
            ack_q      <= 1'b0;
            scl        <= 1'b1;
            sda_out    <= 1'b1;
            cmd_ready  <= 1'b1;
            bus_active <= 1'b0;
            rsp_valid  <= 1'b0;
            rsp_data   <= '0;
            rsp_ack    <= 1'b0;
            rsp_err    <= 1'b0;
        end else begin
            state_q    <= state_n;
            ph_q       <= ph_n;
            bit_q      <= bit_n;
            sh_q       <= sh_n;
            op_q       <= op_n;
            nack_q     <= nack_n;
            ack_q      <= ack_n;
            scl        <= scl_n;
            sda_out    <= sda_n;
            cmd_ready  <= ready_n;
            bus_active <= active_n;
            rsp_valid  <= rv_n;
            rsp_data   <= rd_n;
            rsp_ack    <= ra_n;
            rsp_err    <= re_n;
        end
    end

    // Line values are computed one edge ahead so they appear on the first cycle of each phase.
    always_comb begin
        state_n  = state_q;
        ph_n     = ph_q;
        bit_n    = bit_q;
        sh_n     = sh_q;
        op_n     = op_q;
        nack_n   = nack_q;
        ack_n    = ack_q;
        scl_n    = scl;
        sda_n    = sda_out;
        ready_n  = cmd_ready;
        active_n = bus_active;
        rv_n     = 1'b0;
        rd_n     = rsp_data;
        ra_n     = rsp_ack;
        re_n     = rsp_err;

        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    ready_n = 1'b0;
                    op_n    = cmd_op_e;
                    nack_n  = cmd_nack;
                    sh_n    = cmd_data;
                    bit_n   = '0;
                    ph_n    = '0;
                    case (cmd_op_e)
                        OP_START: begin
                            state_n = ST_START;
                            sda_n   = 1'b1;
                        end
                        OP_WRITE, OP_READ: begin
                            if (bus_active) begin
                                state_n = ST_BIT_LO;
                                scl_n   = 1'b0;
                                sda_n   = (cmd_op_e == OP_WRITE) ? cmd_data[7] : 1'b1;
                            end else begin
                                state_n = ST_RESP;
                            end
                        end
                        default: begin
                            if (bus_active) begin
                                state_n = ST_STOP;
                                scl_n   = 1'b0;
                                sda_n   = 1'b0;
                            end else begin
                                state_n = ST_RESP;
                            end
                        end
                    endcase
                end
            end
            ST_START: begin
                if (tick_end) begin
                    ph_n = ph_q + 2'd1;
                    case (ph_q)
                        2'd0:    scl_n = 1'b1;
                        2'd1:    sda_n = 1'b0;
                        2'd2:    scl_n = 1'b0;
                        default: begin
                            active_n = 1'b1;
                            ready_n  = 1'b1;
                            state_n  = ST_IDLE;
                        end
                    endcase
                end
            end
            ST_BIT_LO: begin
                if (tick_end) begin
                    state_n = ST_BIT_HI;
                    scl_n   = 1'b1;
                end
            end
            ST_BIT_HI: begin
                if (tick_end) begin
                    scl_n = 1'b0;
                    if (bit_q == ACK_BIT) begin
                        ack_n   = !sda_in;
                        state_n = ST_TRAIL;
                    end else begin
                        // Same shifter serves both directions: WRITE drains MSB-first, READ fills LSB-up.
                        sh_n    = {sh_q[6:0], sda_in};
                        bit_n   = bit_q + 4'd1;
                        state_n = ST_BIT_LO;
                        if (bit_q == LAST_DATA_BIT) begin
                            sda_n = (op_q == OP_WRITE) ? 1'b1 : nack_q;
                        end else begin
                            sda_n = (op_q == OP_WRITE) ? sh_q[6] : 1'b1;
                        end
                    end
                end
            end
            ST_TRAIL: begin
                if (tick_end) begin
                    rv_n    = 1'b1;
                    rd_n    = (op_q == OP_READ) ? sh_q : 8'h00;
                    ra_n    = (op_q == OP_WRITE) ? ack_q : 1'b0;
                    re_n    = 1'b0;
                    ready_n = 1'b1;
                    state_n = ST_IDLE;
                end
            end
            ST_STOP: begin
                if (tick_end) begin
                    ph_n = ph_q + 2'd1;
                    case (ph_q)
                        2'd0:    scl_n = 1'b1;
                        2'd1:    sda_n = 1'b1;
                        default: begin
                            active_n = 1'b0;
                            ready_n  = 1'b1;
                            state_n  = ST_IDLE;
                        end
                    endcase
                end
            end
            ST_RESP: begin
                ready_n = 1'b1;
                state_n = ST_IDLE;
                if (op_q != OP_STOP) begin
                    rv_n = 1'b1;
                    rd_n = 8'h00;
                    ra_n = 1'b0;
                    re_n = 1'b1;
                end
            end
            default: state_n = ST_IDLE;
        endcase
    end

endmodule

// File: tb/tb_disbus_master.sv
// tb/tb_disbus_master.sv - directed self-checking bench for disbus_master with HALF=4
module tb_disbus_master;
    import disbus_pkg::*;

    localparam int HALF    = 4;
    localparam int BIT_CYC = 2 * HALF;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       cmd_valid = 1'b0;
    logic       cmd_ready;
    logic [1:0] cmd_op = 2'd0;
    logic [7:0] cmd_data = 8'h00;
    logic       cmd_nack = 1'b0;
    logic       rsp_valid;
    logic [7:0] rsp_data;
    logic       rsp_ack;
    logic       rsp_err;
    logic       bus_active;
    logic       scl;
    logic       sda_out;
    logic       sda_in;
    logic       slave_bit = 1'b1;
    logic       pre_scl, pre_sda;

    int total = 0;
    int bad   = 0;

    assign sda_in = sda_out & slave_bit;

    always #5 clk = ~clk;

    disbus_master #(.HALF(HALF)) dut (
        .clk        (clk),
        .reset      (reset),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .cmd_op     (cmd_op),
        .cmd_data   (cmd_data),
        .cmd_nack   (cmd_nack),
        .rsp_valid  (rsp_valid),
        .rsp_data   (rsp_data),
        .rsp_ack    (rsp_ack),
        .rsp_err    (rsp_err),
        .bus_active (bus_active),
        .scl        (scl),
        .sda_out    (sda_out),
        .sda_in     (sda_in)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // Returns just after the accept edge, i.e. inside cycle 0.
    task automatic send(input logic [1:0] op, input logic [7:0] d, input logic n);
        @(negedge clk);
        chk("ready_before_accept", cmd_ready, 1);
        pre_scl   = scl;
        pre_sda   = sda_out;
        cmd_valid = 1'b1;
        cmd_op    = op;
        cmd_data  = d;
        cmd_nack  = n;
        @(posedge clk);
        #1 cmd_valid = 1'b0;
    endtask

    task automatic run_ctl(output int sf, output int sr, output int cf, output int cr,
                           output int rdy, output logic scl_at_sf);
        logic ps, pd;
        ps = pre_scl; pd = pre_sda;
        sf = -1; sr = -1; cf = -1; cr = -1; rdy = -1; scl_at_sf = 1'bx;
        for (int k = 0; k < 100 && rdy < 0; k++) begin
            @(negedge clk);
            if (pd && !sda_out && sf < 0) begin sf = k; scl_at_sf = scl; end
            if (!pd && sda_out && sr < 0) sr = k;
            if (ps && !scl && cf < 0) cf = k;
            if (!ps && scl && cr < 0) cr = k;
            if (cmd_ready) rdy = k;
            ps = scl; pd = sda_out;
        end
    endtask

    task automatic run_byte(input logic [7:0] rd_byte, input logic do_read, input logic ack_low,
                            output int vcyc, output logic [7:0] seen, output logic ack_sda,
                            output int viol, output logic rdy_at_v);
        logic ps, pd;
        int   nbit, idx;
        ps = pre_scl; pd = pre_sda;
        vcyc = -1; seen = 8'h00; ack_sda = 1'bx; viol = 0; nbit = 0; rdy_at_v = 1'bx;
        for (int k = 0; k < 200 && vcyc < 0; k++) begin
            @(negedge clk);
            if (!ps && scl) begin
                if (nbit < 8) seen[7 - nbit] = sda_out;
                else if (nbit == 8) ack_sda = sda_out;
                nbit++;
            end
            if (ps && scl && sda_out !== pd) viol++;
            if (rsp_valid) begin vcyc = k; rdy_at_v = cmd_ready; end
            ps = scl; pd = sda_out;
            idx = k / BIT_CYC;
            if (do_read) slave_bit = (idx < 8) ? rd_byte[7 - idx] : 1'b1;
            else         slave_bit = (idx == 8 && ack_low) ? 1'b0 : 1'b1;
        end
        slave_bit = 1'b1;
    endtask

    initial begin
        int         sf, sr, cf, cr, rdy, vcyc, viol;
        logic       scl_sf, ack_sda, rdy_v;
        logic [7:0] seen;

        repeat (3) @(negedge clk);
        chk("reset_lines", {scl, sda_out, cmd_ready, rsp_valid, rsp_ack, rsp_err, bus_active}, 7'b1110000);
        chk("reset_rsp_data", rsp_data, 8'h00);
        reset = 1'b1;

        send(OP_WRITE, 8'h55, 1'b0);
        @(negedge clk);
        chk("nostart_c0_valid_ready", {rsp_valid, cmd_ready}, 2'b00);
        @(negedge clk);
        chk("nostart_c1_rsp", {rsp_valid, rsp_err, rsp_ack, cmd_ready, scl, sda_out}, 6'b110111);
        chk("nostart_c1_data", rsp_data, 8'h00);
        @(negedge clk);
        chk("nostart_c2_hold", {rsp_valid, rsp_err, scl}, 3'b011);

        send(OP_STOP, 8'h00, 1'b0);
        @(negedge clk);
        chk("stop_idle_c0_ready", cmd_ready, 0);
        @(negedge clk);
        chk("stop_idle_c1", {cmd_ready, rsp_valid, scl, sda_out, bus_active}, 5'b10110);

        send(OP_START, 8'h00, 1'b0);
        run_ctl(sf, sr, cf, cr, rdy, scl_sf);
        chk("start_sda_fall", sf, 8);
        chk("start_scl_at_fall", scl_sf, 1);
        chk("start_scl_fall", cf, 12);
        chk("start_ready", rdy, 16);
        chk("start_active", bus_active, 1);

        send(OP_WRITE, 8'hA5, 1'b0);
        run_byte(8'h00, 1'b0, 1'b1, vcyc, seen, ack_sda, viol, rdy_v);
        chk("wr_a5_latency", vcyc, 76);
        chk("wr_a5_bits", seen, 8'hA5);
        chk("wr_a5_ack_released", ack_sda, 1);
        chk("wr_a5_stable_high", viol, 0);
        chk("wr_a5_ready_with_valid", rdy_v, 1);
        chk("wr_a5_rsp", {rsp_ack, rsp_err, rsp_data}, {1'b1, 1'b0, 8'h00});

        send(OP_WRITE, 8'h74, 1'b0);
        run_byte(8'h00, 1'b0, 1'b0, vcyc, seen, ack_sda, viol, rdy_v);
        chk("wr_74_latency", vcyc, 76);
        chk("wr_74_bits", seen, 8'h74);
        chk("wr_74_stable_high", viol, 0);
        chk("wr_74_rsp", {rsp_ack, rsp_err, rsp_data}, {1'b0, 1'b0, 8'h00});

        send(OP_READ, 8'h00, 1'b1);
        run_byte(8'h3C, 1'b1, 1'b0, vcyc, seen, ack_sda, viol, rdy_v);
        chk("rd_3c_latency", vcyc, 76);
        chk("rd_3c_released", seen, 8'hFF);
        chk("rd_3c_nack_sda", ack_sda, 1);
        chk("rd_3c_rsp", {rsp_ack, rsp_err, rsp_data}, {1'b0, 1'b0, 8'h3C});

        send(OP_READ, 8'h00, 1'b0);
        run_byte(8'hC3, 1'b1, 1'b0, vcyc, seen, ack_sda, viol, rdy_v);
        chk("rd_c3_latency", vcyc, 76);
        chk("rd_c3_ack_sda", ack_sda, 0);
        chk("rd_c3_stable_high", viol, 0);
        chk("rd_c3_rsp", {rsp_ack, rsp_err, rsp_data}, {1'b0, 1'b0, 8'hC3});

        send(OP_STOP, 8'h00, 1'b0);
        run_ctl(sf, sr, cf, cr, rdy, scl_sf);
        chk("stop_scl_rise", cr, 4);
        chk("stop_sda_rise", sr, 8);
        chk("stop_ready", rdy, 12);
        chk("stop_end_lines", {bus_active, scl, sda_out}, 3'b011);

        send(OP_START, 8'h00, 1'b0);
        run_ctl(sf, sr, cf, cr, rdy, scl_sf);
        chk("start2_ready", rdy, 16);
        send(OP_WRITE, 8'h00, 1'b0);
        repeat (34) @(negedge clk);
        chk("midwr_bit3_low", {scl, sda_out, cmd_ready}, 3'b000);
        #1 reset = 1'b0;
        #1;
        chk("midwr_reset_lines", {scl, sda_out, cmd_ready, bus_active, rsp_valid}, 5'b11100);
        @(negedge clk);
        chk("midwr_reset_hold", {scl, sda_out, cmd_ready, bus_active, rsp_valid}, 5'b11100);
        @(negedge clk);
        chk("midwr_reset_no_valid", rsp_valid, 0);
        reset = 1'b1;

        send(OP_START, 8'h00, 1'b0);
        run_ctl(sf, sr, cf, cr, rdy, scl_sf);
        chk("restart_sda_fall", sf, 8);
        chk("restart_scl_fall", cf, 12);
        chk("restart_ready", rdy, 16);
        chk("restart_active", bus_active, 1);

        send(OP_WRITE, 8'h3C, 1'b0);
        run_byte(8'h00, 1'b0, 1'b1, vcyc, seen, ack_sda, viol, rdy_v);
        chk("wr_3c_latency", vcyc, 76);
        chk("wr_3c_bits", seen, 8'h3C);
        chk("wr_3c_ack", rsp_ack, 1);

        send(OP_STOP, 8'h00, 1'b0);
        run_ctl(sf, sr, cf, cr, rdy, scl_sf);
        chk("stop2_ready", rdy, 12);
        chk("stop2_inactive", bus_active, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
